control_unit: RTL and testbench

- Sequencing FSM for the YASAC data unit.
- Takes opcode, s and status from the data unit and drives every one of its control strobes, one instruction at a time: INIT, then FETCH, then 1-3 EXEC steps.
- Sits beside the data unit inside the computer top level; the two blocks share only the control bus and the opcode/s/status lines.

---
 rtl/control_unit_pkg.sv | 77 +++++++
 rtl/control_unit.sv | 216 +++++++++++++++++++++
 tb/tb_control_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_pkg.sv
// ----------------------------------------------------------------------------
// control_unit_pkg
// Shared definitions for the YASAC control unit:
//   - instruction opcodes (ir[15:11]), including the two ALU groups 10ooo/11ooo
//   - ALU operation codes driven on the op bus
//   - FSM state encoding
//   - RAMEND, the initial (top-of-RAM) stack pointer value
//   - small decode helpers shared by the FSM and the strobe decoder
// ----------------------------------------------------------------------------
package control_unit_pkg;

    // Instruction opcodes
    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LD   = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_JMP  = 5'b00100;
    localparam logic [4:0] OP_BRS  = 5'b00101;
    localparam logic [4:0] OP_BRC  = 5'b00110;
    localparam logic [4:0] OP_CALL = 5'b00111;
    localparam logic [4:0] OP_RET  = 5'b01000;
    localparam logic [4:0] OP_SETB = 5'b01001;
    localparam logic [4:0] OP_CLRB = 5'b01010;
    localparam logic [4:0] OP_HALT = 5'b01111;

    // ALU operation codes; the low three bits double as the ooo field of
    // the ALU instruction groups, so op = {1'b0, ooo} needs no translation.
    localparam logic [3:0] ALU_TRA = 4'd0;
    localparam logic [3:0] ALU_TRB = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_OR  = 4'd5;
    localparam logic [3:0] ALU_XOR = 4'd6;
    localparam logic [3:0] ALU_CMP = 4'd7;

    // Initial stack pointer (top of data RAM)
    localparam logic [7:0] RAMEND = 8'hFF;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EX1   = 3'd2,
        ST_EX2   = 3'd3,
        ST_EX3   = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    // True when the opcode belongs to one of the ALU groups (1xxxx)
    function automatic logic is_alu(input logic [4:0] opc);
        return opc[4];
    endfunction

    // True for every opcode the instruction set defines
    function automatic logic is_defined(input logic [4:0] opc);
        logic ok;
        case (opc)
            OP_NOP, OP_LD, OP_ST, OP_LDI, OP_JMP, OP_BRS, OP_BRC,
            OP_CALL, OP_RET, OP_SETB, OP_CLRB, OP_HALT: ok = 1'b1;
            default: ok = is_alu(opc);
        endcase
        return ok;
    endfunction

    // Number of EX steps an instruction needs (FETCH not included)
    function automatic logic [1:0] exec_steps(input logic [4:0] opc);
        logic [1:0] n;
        case (opc)
            OP_LD, OP_ST:    n = 2'd2;
            OP_CALL, OP_RET: n = 2'd3;
            default:         n = 2'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
// Sequencing FSM for the YASAC data unit. One instruction at a time it steps
// INIT -> FETCH -> EX1 [-> EX2 [-> EX3]] -> FETCH ..., and decodes
// (state, opcode, s, status) into the data-unit control strobes.
//
// Parameters:
//   HALT_ON_ILLEGAL  1: undefined opcode enters HALT; 0: executes as NOP
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high; forces INIT
//   opcode   in   ir[15:11]
//   s        in   status-bit selector ir[10:8]
//   status   in   status register (---SVNZC)
//   op       out  ALU operation code
//   ipc .. rsp  out  data-unit strobes (combinational from state/inputs)
//   halted   out  high while in HALT
// ----------------------------------------------------------------------------
module control_unit
    import control_unit_pkg::*;
#(
    parameter int unsigned HALT_ON_ILLEGAL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] opcode,
    input  logic [2:0] s,
    input  logic [7:0] status,
    output logic [3:0] op,
    output logic       ipc,
    output logic       clpc,
    output logic       wpc,
    output logic       rpc,
    output logic       wir,
    output logic       wreg,
    output logic       inm,
    output logic       wmem,
    output logic       rmem,
    output logic       wmar,
    output logic       wsreg,
    output logic       clsb,
    output logic       sesb,
    output logic       prsp,
    output logic       incsp,
    output logic       decsp,
    output logic       rsp,
    output logic       halted
);

    state_t     state_r;
    logic       cond_bit_s;
    logic       illegal_s;
    logic       stop_s;
    logic [1:0] steps_s;

    assign cond_bit_s = status[s];
    assign illegal_s  = ~is_defined(opcode);
    assign steps_s    = exec_steps(opcode);
    // HALT, or an undefined opcode when configured to trap, ends in HALT
    assign stop_s     = (opcode == OP_HALT) ||
                        (illegal_s && (HALT_ON_ILLEGAL != 0));

    // State sequencing; reset abandons any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_INIT;
        end else begin
            case (state_r)
                ST_INIT:  state_r <= ST_FETCH;
                ST_FETCH: state_r <= ST_EX1;
                ST_EX1: begin
                    if (stop_s) begin
                        state_r <= ST_HALT;
                    end else if (steps_s > 2'd1) begin
                        state_r <= ST_EX2;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_EX2: begin
                    if (steps_s > 2'd2) begin
                        state_r <= ST_EX3;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_EX3:  state_r <= ST_FETCH;
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_INIT;
            endcase
        end
    end

    // Strobe decode; everything idles at 0 / ALU_TRA unless a step drives it
    always_comb begin
        op     = ALU_TRA;
        ipc    = 1'b0;
        clpc   = 1'b0;
        wpc    = 1'b0;
        rpc    = 1'b0;
        wir    = 1'b0;
        wreg   = 1'b0;
        inm    = 1'b0;
        wmem   = 1'b0;
        rmem   = 1'b0;
        wmar   = 1'b0;
        wsreg  = 1'b0;
        clsb   = 1'b0;
        sesb   = 1'b0;
        prsp   = 1'b0;
        incsp  = 1'b0;
        decsp  = 1'b0;
        rsp    = 1'b0;
        halted = 1'b0;

        case (state_r)
            ST_INIT: begin
                clpc = 1'b1;
                prsp = 1'b1;
            end
            ST_FETCH: begin
                // IR <= mem[pc] and pc+1 on the same edge
                wir = 1'b1;
                ipc = 1'b1;
            end
            ST_EX1: begin
                casez (opcode)
                    OP_LD, OP_ST: begin
                        op   = ALU_TRB;
                        wmar = 1'b1;
                    end
                    OP_LDI: begin
                        op   = ALU_TRB;
                        inm  = 1'b1;
                        wreg = 1'b1;
                    end
                    OP_JMP: begin
                        op  = ALU_TRB;
                        inm = 1'b1;
                        wpc = 1'b1;
                    end
                    OP_BRS: begin
                        op  = ALU_TRB;
                        inm = 1'b1;
                        wpc = cond_bit_s;
                    end
                    OP_BRC: begin
                        op  = ALU_TRB;
                        inm = 1'b1;
                        wpc = ~cond_bit_s;
                    end
                    OP_CALL: begin
                        // MAR <= SP: push address (post-decrement follows)
                        rsp  = 1'b1;
                        wmar = 1'b1;
                    end
                    OP_RET: begin
                        // pre-increment before the pop
                        incsp = 1'b1;
                    end
                    OP_SETB: sesb = 1'b1;
                    OP_CLRB: clsb = 1'b1;
                    5'b1????: begin
                        // ALU groups: 10ooo reg-reg, 11ooo reg-imm
                        op    = {1'b0, opcode[2:0]};
                        wsreg = 1'b1;
                        wreg  = ({1'b0, opcode[2:0]} != ALU_CMP);
                        inm   = opcode[3];
                    end
                    default: op = ALU_TRA; // NOP, HALT, undefined
                endcase
            end
            ST_EX2: begin
                case (opcode)
                    OP_LD: begin
                        rmem = 1'b1;
                        wreg = 1'b1;
                    end
                    OP_ST: begin
                        op   = ALU_TRA;
                        wmem = 1'b1;
                    end
                    OP_CALL: begin
                        // pc was already incremented in FETCH: it is the return address
                        rpc   = 1'b1;
                        wmem  = 1'b1;
                        decsp = 1'b1;
                    end
                    OP_RET: begin
                        rsp  = 1'b1;
                        wmar = 1'b1;
                    end
                    default: op = ALU_TRA;
                endcase
            end
            ST_EX3: begin
                case (opcode)
                    OP_CALL: begin
                        op  = ALU_TRB;
                        inm = 1'b1;
                        wpc = 1'b1;
                    end
                    OP_RET: begin
                        rmem = 1'b1;
                        wpc  = 1'b1;
                    end
                    default: op = ALU_TRA;
                endcase
            end
            ST_HALT: halted = 1'b1;
            default: op = ALU_TRA;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// ----------------------------------------------------------------------------
// tb_control_unit
// Directed bench for control_unit. Two instances share the inputs: dut with
// HALT_ON_ILLEGAL=0 (main checks) and dut_h with HALT_ON_ILLEGAL=1 (trap on
// undefined opcode). Outputs are compared as one packed vector
// {op, strobes, halted} against hand-computed values.
// ----------------------------------------------------------------------------
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] opcode;
    logic [2:0] s;
    logic [7:0] status;

    logic [3:0] op;
    logic ipc, clpc, wpc, rpc, wir, wreg, inm, wmem, rmem, wmar;
    logic wsreg, clsb, sesb, prsp, incsp, decsp, rsp, halted;

    logic [3:0]  op_h;
    logic [16:0] strb_h;
    logic        halted_h;

    int vecs = 0;
    int errs = 0;

    // strobe masks, order {ipc..rsp}
    localparam logic [16:0] M_IPC   = 17'h10000;
    localparam logic [16:0] M_CLPC  = 17'h08000;
    localparam logic [16:0] M_WPC   = 17'h04000;
    localparam logic [16:0] M_RPC   = 17'h02000;
    localparam logic [16:0] M_WIR   = 17'h01000;
    localparam logic [16:0] M_WREG  = 17'h00800;
    localparam logic [16:0] M_INM   = 17'h00400;
    localparam logic [16:0] M_WMEM  = 17'h00200;
    localparam logic [16:0] M_RMEM  = 17'h00100;
    localparam logic [16:0] M_WMAR  = 17'h00080;
    localparam logic [16:0] M_WSREG = 17'h00040;
    localparam logic [16:0] M_CLSB  = 17'h00020;
    localparam logic [16:0] M_SESB  = 17'h00010;
    localparam logic [16:0] M_PRSP  = 17'h00008;
    localparam logic [16:0] M_INCSP = 17'h00004;
    localparam logic [16:0] M_DECSP = 17'h00002;
    localparam logic [16:0] M_RSP   = 17'h00001;
    localparam logic [16:0] M_NONE  = 17'h00000;

    localparam logic [3:0] TRA = 4'd0;
    localparam logic [3:0] TRB = 4'd1;
    localparam logic [3:0] ADD = 4'd2;
    localparam logic [3:0] CMP = 4'd7;

    logic [21:0] obs;
    logic [21:0] obs_h;
    assign obs   = {op, ipc, clpc, wpc, rpc, wir, wreg, inm, wmem, rmem, wmar,
                    wsreg, clsb, sesb, prsp, incsp, decsp, rsp, halted};
    assign obs_h = {op_h, strb_h, halted_h};

    control_unit #(.HALT_ON_ILLEGAL(0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .s(s), .status(status),
        .op(op), .ipc(ipc), .clpc(clpc), .wpc(wpc), .rpc(rpc), .wir(wir),
        .wreg(wreg), .inm(inm), .wmem(wmem), .rmem(rmem), .wmar(wmar),
        .wsreg(wsreg), .clsb(clsb), .sesb(sesb), .prsp(prsp), .incsp(incsp),
        .decsp(decsp), .rsp(rsp), .halted(halted)
    );

    control_unit #(.HALT_ON_ILLEGAL(1)) dut_h (
        .clk(clk), .reset(reset), .opcode(opcode), .s(s), .status(status),
        .op(op_h), .ipc(strb_h[16]), .clpc(strb_h[15]), .wpc(strb_h[14]),
        .rpc(strb_h[13]), .wir(strb_h[12]), .wreg(strb_h[11]), .inm(strb_h[10]),
        .wmem(strb_h[9]), .rmem(strb_h[8]), .wmar(strb_h[7]), .wsreg(strb_h[6]),
        .clsb(strb_h[5]), .sesb(strb_h[4]), .prsp(strb_h[3]), .incsp(strb_h[2]),
        .decsp(strb_h[1]), .rsp(strb_h[0]), .halted(halted_h)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] mk(input logic [3:0] o, input logic [16:0] m,
                                       input logic h);
        return {o, m, h};
    endfunction

    task automatic chk(input string tag, input logic [21:0] e);
        vecs++;
        assert (obs === e) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic chk_h(input string tag, input logic [21:0] e);
        vecs++;
        assert (obs_h === e) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_h, e);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FETCH cycle: load the next instruction's fields, check fetch strobes
    task automatic fetch(input string tag, input logic [4:0] opc,
                         input logic [2:0] sel, input logic [7:0] st);
        tick();
        opcode = opc;
        s      = sel;
        status = st;
        #1;
        chk(tag, mk(TRA, M_WIR | M_IPC, 1'b0));
    endtask

    task automatic step(input string tag, input logic [21:0] e);
        tick();
        #1;
        chk(tag, e);
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 5'b00000;
        s      = 3'd0;
        status = 8'h00;

        // 1. reset and INIT
        #2;
        chk("reset_assert", mk(TRA, M_CLPC | M_PRSP, 1'b0));
        tick();
        tick();
        chk("reset_held", mk(TRA, M_CLPC | M_PRSP, 1'b0));
        reset = 1'b0;
        #1;
        chk("init", mk(TRA, M_CLPC | M_PRSP, 1'b0));

        // 2. LDI R1,5 ; ADDI R1,3 ; ST (R2),R1
        fetch("fetch_ldi", 5'b00011, 3'd0, 8'h00);
        chk_h("fetch_h", mk(TRA, M_WIR | M_IPC, 1'b0));
        step("ldi_ex1", mk(TRB, M_INM | M_WREG, 1'b0));
        fetch("fetch_addi", 5'b11010, 3'd0, 8'h00);
        step("addi_ex1", mk(ADD, M_INM | M_WREG | M_WSREG, 1'b0));
        fetch("fetch_st", 5'b00010, 3'd0, 8'h00);
        step("st_ex1", mk(TRB, M_WMAR, 1'b0));
        step("st_ex2", mk(TRA, M_WMEM, 1'b0));

        // ALU corner cases: CMP suppresses wreg, reg-reg has no inm
        fetch("fetch_cmp", 5'b10111, 3'd0, 8'h00);
        step("cmp_ex1", mk(CMP, M_WSREG, 1'b0));
        fetch("fetch_cmpi", 5'b11111, 3'd0, 8'h00);
        step("cmpi_ex1", mk(CMP, M_WSREG | M_INM, 1'b0));
        fetch("fetch_add", 5'b10010, 3'd0, 8'h00);
        step("add_ex1", mk(ADD, M_WSREG | M_WREG, 1'b0));

        // 3. branches on status bit
        fetch("fetch_brs", 5'b00101, 3'd0, 8'h01);
        step("brs_taken", mk(TRB, M_INM | M_WPC, 1'b0));
        fetch("fetch_brc", 5'b00110, 3'd0, 8'h01);
        step("brc_not_taken", mk(TRB, M_INM, 1'b0));
        fetch("fetch_brs3", 5'b00101, 3'd3, 8'hF7);
        step("brs_s3_not_taken", mk(TRB, M_INM, 1'b0));
        fetch("fetch_brc3", 5'b00110, 3'd3, 8'hF7);
        step("brc_s3_taken", mk(TRB, M_INM | M_WPC, 1'b0));

        // JMP, LD, SETB, CLRB, NOP
        fetch("fetch_jmp", 5'b00100, 3'd0, 8'h00);
        step("jmp_ex1", mk(TRB, M_INM | M_WPC, 1'b0));
        fetch("fetch_ld", 5'b00001, 3'd0, 8'h00);
        step("ld_ex1", mk(TRB, M_WMAR, 1'b0));
        step("ld_ex2", mk(TRA, M_RMEM | M_WREG, 1'b0));
        fetch("fetch_setb", 5'b01001, 3'd2, 8'h00);
        step("setb_ex1", mk(TRA, M_SESB, 1'b0));
        fetch("fetch_clrb", 5'b01010, 3'd2, 8'h00);
        step("clrb_ex1", mk(TRA, M_CLSB, 1'b0));
        fetch("fetch_nop", 5'b00000, 3'd0, 8'h00);
        step("nop_ex1", mk(TRA, M_NONE, 1'b0));

        // 4. CALL then RET
        fetch("fetch_call", 5'b00111, 3'd0, 8'h00);
        step("call_ex1", mk(TRA, M_RSP | M_WMAR, 1'b0));
        step("call_ex2", mk(TRA, M_RPC | M_WMEM | M_DECSP, 1'b0));
        step("call_ex3", mk(TRB, M_INM | M_WPC, 1'b0));
        fetch("fetch_ret", 5'b01000, 3'd0, 8'h00);
        step("ret_ex1", mk(TRA, M_INCSP, 1'b0));
        step("ret_ex2", mk(TRA, M_RSP | M_WMAR, 1'b0));
        step("ret_ex3", mk(TRA, M_RMEM | M_WPC, 1'b0));

        // 5. reset during EX2 of CALL
        fetch("fetch_call2", 5'b00111, 3'd0, 8'h00);
        step("call2_ex1", mk(TRA, M_RSP | M_WMAR, 1'b0));
        step("call2_ex2", mk(TRA, M_RPC | M_WMEM | M_DECSP, 1'b0));
        reset = 1'b1;
        #1;
        chk("reset_mid_call", mk(TRA, M_CLPC | M_PRSP, 1'b0));
        tick();
        reset = 1'b0;
        #1;
        chk("init_after_abort", mk(TRA, M_CLPC | M_PRSP, 1'b0));

        // 6a. undefined opcode 01100: NOP in dut, HALT in dut_h
        fetch("fetch_illegal", 5'b01100, 3'd0, 8'h00);
        step("illegal_ex1", mk(TRA, M_NONE, 1'b0));
        chk_h("illegal_ex1_h", mk(TRA, M_NONE, 1'b0));
        fetch("illegal_nop_timing", 5'b01111, 3'd0, 8'h00);
        chk_h("illegal_trap_h", mk(TRA, M_NONE, 1'b1));

        // 6b. HALT: absorbing regardless of inputs
        step("halt_ex1", mk(TRA, M_NONE, 1'b0));
        step("halted", mk(TRA, M_NONE, 1'b1));
        for (int i = 0; i < 4; i++) begin
            tick();
            opcode = 5'(i * 7 + 3);
            s      = 3'(i);
            status = 8'hFF;
            #1;
            chk("halt_absorbing", mk(TRA, M_NONE, 1'b1));
            chk_h("halt_absorbing_h", mk(TRA, M_NONE, 1'b1));
        end

        // reset releases HALT
        reset = 1'b1;
        #1;
        chk("halt_reset", mk(TRA, M_CLPC | M_PRSP, 1'b0));
        chk_h("halt_reset_h", mk(TRA, M_CLPC | M_PRSP, 1'b0));
        tick();
        reset = 1'b0;
        fetch("fetch_after_halt", 5'b00000, 3'd0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
